// File: rtl/imu_bias_calib.sv
// imu_bias_calib: multi-channel zero-offset calibrator for the MPU6050 pose pipeline.
// Drops DISCARD_SAMPLES warm-up samples, then averages 2^LOG2_SAMPLES samples per
// channel (truncation toward zero) and publishes the signed per-channel bias.
// A key pulse restarts the run; the last good bias is held until a new one is ready.
// Optional feature macro: BIAS_SUBTRACT_EN adds corr_out/corr_valid_out, which carry
// saturated (sample - bias) for every strobe seen while DONE.
module imu_bias_calib #(
  parameter int NUM_CH          = 7,
  parameter int DATA_W          = 16,
  parameter int LOG2_SAMPLES    = 10,
  parameter int DISCARD_SAMPLES = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     sample_valid_in,
  input  logic                     config_done,
  input  logic                     key_flag_in,
  output logic                     calib_done_out,
  output logic                     busy_out,
  output logic [NUM_CH*DATA_W-1:0] bias_out
`ifdef BIAS_SUBTRACT_EN
  ,
  output logic [NUM_CH*DATA_W-1:0] corr_out,
  output logic                     corr_valid_out
`endif
);

  localparam int AW = DATA_W + LOG2_SAMPLES;
  localparam int CW = (LOG2_SAMPLES > 8) ? LOG2_SAMPLES : 8;
  localparam logic [CW-1:0] ACC_LAST  = CW'((1 << LOG2_SAMPLES) - 1);
  localparam logic [CW-1:0] DISC_LAST = CW'((DISCARD_SAMPLES == 0) ? 0 : DISCARD_SAMPLES - 1);
  localparam logic signed [AW-1:0] ROUND = AW'((1 << LOG2_SAMPLES) - 1);

  typedef enum logic [2:0] {IDLE, DISCARD, ACCUM, DIVIDE, DONE} state_t;

  state_t                     state_q, state_d, start_st;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic signed [AW-1:0]       acc_q [NUM_CH];
  logic signed [AW-1:0]       acc_d [NUM_CH];
  logic signed [AW-1:0]       samp  [NUM_CH];
  logic signed [AW-1:0]       rnd   [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   avg_w;
  logic [NUM_CH*DATA_W-1:0]   bias_q, bias_d;
  logic                       calib_done_q, calib_done_d;
  logic                       busy_q, busy_d;
  logic                       clr_run;

  assign start_st = (DISCARD_SAMPLES == 0) ? ACCUM : DISCARD;

  // Sign-extend each channel sample to accumulator width
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      samp[c] = {{LOG2_SAMPLES{data_in[c*DATA_W + DATA_W - 1]}}, data_in[c*DATA_W +: DATA_W]};
    end
  end

  // Average with truncation toward zero: bias negative sums up by 2^L-1 before the shift
  always_comb begin
    avg_w = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      rnd[c] = acc_q[c][AW-1] ? (acc_q[c] + ROUND) : acc_q[c];
      avg_w[c*DATA_W +: DATA_W] = DATA_W'(rnd[c] >>> LOG2_SAMPLES);
    end
  end

  // Next-state logic: config_done drop beats key, key beats sample strobe
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    bias_d       = bias_q;
    calib_done_d = calib_done_q;
    clr_run      = 1'b0;

    if (state_q != IDLE && !config_done) begin
      state_d      = IDLE;
      calib_done_d = 1'b0;
      clr_run      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (config_done) begin
            state_d = start_st;
            clr_run = 1'b1;
          end
        end
        DISCARD: begin
          if (key_flag_in) begin
            state_d = start_st;
            clr_run = 1'b1;
          end else if (sample_valid_in) begin
            if (cnt_q == DISC_LAST) begin
              state_d = ACCUM;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ACCUM: begin
          if (key_flag_in) begin
            state_d = start_st;
            clr_run = 1'b1;
          end else if (sample_valid_in) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              acc_d[c] = acc_q[c] + samp[c];
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ACC_LAST) begin
              state_d = DIVIDE;
            end
          end
        end
        DIVIDE: begin
          bias_d       = avg_w;
          calib_done_d = 1'b1;
          state_d      = DONE;
        end
        DONE: begin
          if (key_flag_in) begin
            calib_done_d = 1'b0;
            state_d      = start_st;
            clr_run      = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          clr_run = 1'b1;
        end
      endcase
    end

    if (clr_run) begin
      cnt_d = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_d[c] = '0;
      end
    end

    busy_d = (state_d == DISCARD) || (state_d == ACCUM) || (state_d == DIVIDE);
  end

  // State, counter, accumulator and output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bias_q       <= '0;
      calib_done_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bias_q       <= bias_d;
      calib_done_q <= calib_done_d;
      busy_q       <= busy_d;
      acc_q        <= acc_d;
    end
  end

  assign calib_done_out = calib_done_q;
  assign busy_out       = busy_q;
  assign bias_out       = bias_q;

`ifdef BIAS_SUBTRACT_EN
  logic signed [DATA_W:0]     diff [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   corr_q, corr_d;
  logic                       corr_valid_q, corr_valid_d;

  // Bias-corrected sample, saturated to DATA_W, captured for each strobe while DONE
  always_comb begin
    corr_d       = corr_q;
    corr_valid_d = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      diff[c] = {data_in[c*DATA_W + DATA_W - 1], data_in[c*DATA_W +: DATA_W]}
              - {bias_q[c*DATA_W + DATA_W - 1], bias_q[c*DATA_W +: DATA_W]};
    end
    if (state_q == DONE && config_done && !key_flag_in && sample_valid_in) begin
      corr_valid_d = 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (diff[c][DATA_W] != diff[c][DATA_W-1]) begin
          corr_d[c*DATA_W +: DATA_W] = diff[c][DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
          corr_d[c*DATA_W +: DATA_W] = diff[c][DATA_W-1:0];
        end
      end
    end
  end

  // Correction output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      corr_q       <= '0;
      corr_valid_q <= 1'b0;
    end else begin
      corr_q       <= corr_d;
      corr_valid_q <= corr_valid_d;
    end
  end

  assign corr_out       = corr_q;
  assign corr_valid_out = corr_valid_q;
`endif

endmodule

// File: tb/tb_imu_bias_calib.sv
// Directed testbench for imu_bias_calib: default-parameter instance plus a
// small instance (LOG2_SAMPLES=3, DISCARD_SAMPLES=4) for the warm-up path.
module tb_imu_bias_calib;

  logic         clk;
  logic         rst_n, cfg, valid, key;
  logic [111:0] data;
  logic         done, busy;
  logic [111:0] bias;
`ifdef BIAS_SUBTRACT_EN
  logic [111:0] corr, s_corr;
  logic         corr_v, s_corr_v;
`endif

  logic         s_rst_n, s_cfg, s_valid, s_key;
  logic [111:0] s_data;
  logic         s_done, s_busy;
  logic [111:0] s_bias;

  int tests = 0;
  int fails = 0;

  imu_bias_calib u_dut (
    .clk_in(clk), .rst_n(rst_n), .data_in(data), .sample_valid_in(valid),
    .config_done(cfg), .key_flag_in(key), .calib_done_out(done),
    .busy_out(busy), .bias_out(bias)
`ifdef BIAS_SUBTRACT_EN
    , .corr_out(corr), .corr_valid_out(corr_v)
`endif
  );

  imu_bias_calib #(.LOG2_SAMPLES(3), .DISCARD_SAMPLES(4)) u_small (
    .clk_in(clk), .rst_n(s_rst_n), .data_in(s_data), .sample_valid_in(s_valid),
    .config_done(s_cfg), .key_flag_in(s_key), .calib_done_out(s_done),
    .busy_out(s_busy), .bias_out(s_bias)
`ifdef BIAS_SUBTRACT_EN
    , .corr_out(s_corr), .corr_valid_out(s_corr_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [111:0] pack7(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6);
    return {16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [111:0] d);
    data  = d;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic strobe_s(input logic [111:0] d);
    s_data  = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic key_pulse();
    key = 1'b1;
    step();
    key = 1'b0;
  endtask

  logic [111:0] v1, v100, v7, v5k, bneg, exp_v;
  int off [7] = '{1353, -370, -68, -20, -112, -35, -44};
  int sum [7];
  int smp [7];

  initial begin
    rst_n = 1'b0; cfg = 1'b0; valid = 1'b0; key = 1'b0; data = '0;
    s_rst_n = 1'b0; s_cfg = 1'b0; s_valid = 1'b0; s_key = 1'b0; s_data = '0;
    v1   = pack7(1353, -370, 0, 0, 0, 0, -44);
    v100 = pack7(100, 0, 0, 0, 0, 0, 0);
    v7   = pack7(7, 7, 7, 7, 7, 7, 7);
    v5k  = pack7(5000, 5000, 5000, 5000, 5000, 5000, 5000);
    bneg = pack7(0, 0, -1, -1, 1, 0, 0);
    #12;
    chk("rst_bias", bias, '0);
    chk("rst_done", {111'd0, done}, 112'd0);
    chk("rst_busy", {111'd0, busy}, 112'd0);
    chk("rst_small_bias", s_bias, '0);
    rst_n = 1'b1; s_rst_n = 1'b1;
    step();

    // Constant input run
    cfg = 1'b1;
    step();
    chk("t1_busy", {111'd0, busy}, 112'd1);
    repeat (1023) strobe(v1);
    chk("t1_not_done_1023", {111'd0, done}, 112'd0);
    strobe(v1);
    chk("t1_latency_divide", {111'd0, done}, 112'd0);
    step();
    chk("t1_done", {111'd0, done}, 112'd1);
    chk("t1_bias", bias, v1);
    chk("t1_busy_idle", {111'd0, busy}, 112'd0);

    // Strobe in DONE is ignored
    strobe(pack7(9999, 9999, 9999, 9999, 9999, 9999, 9999));
    step();
    chk("done_strobe_bias", bias, v1);
    chk("done_strobe_done", {111'd0, done}, 112'd1);

    // Recalibrate: old bias held while running
    key_pulse();
    chk("t3_done_low", {111'd0, done}, 112'd0);
    chk("t3_bias_held", bias, v1);
    chk("t3_busy", {111'd0, busy}, 112'd1);
    repeat (1024) strobe(v100);
    step();
    chk("t3_bias100", bias, v100);
    chk("t3_done", {111'd0, done}, 112'd1);

`ifdef BIAS_SUBTRACT_EN
    strobe(pack7(-32768, 500, 0, 0, 0, 0, 0));
    chk("t6_corr_valid", {111'd0, corr_v}, 112'd1);
    chk("t6_corr_sat", corr, pack7(-32768, 500, 0, 0, 0, 0, 0));
    step();
    chk("t6_corr_valid_pulse", {111'd0, corr_v}, 112'd0);
    strobe(pack7(500, 0, 0, 0, 0, 0, 0));
    chk("t6_corr_400", corr, pack7(400, 0, 0, 0, 0, 0, 0));
`endif

    // Key mid-ACCUM restarts; the sample on the key edge is dropped
    key_pulse();
    repeat (10) strobe(v5k);
    data = v5k; valid = 1'b1; key = 1'b1;
    step();
    valid = 1'b0; key = 1'b0;
    repeat (1023) strobe(v7);
    chk("restart_not_done_1023", {111'd0, done}, 112'd0);
    strobe(v7);
    step();
    chk("restart_bias", bias, v7);
    chk("restart_done", {111'd0, done}, 112'd1);

    // Random offsets around realistic biases
    key_pulse();
    for (int c = 0; c < 7; c++) sum[c] = 0;
    for (int n = 0; n < 1024; n++) begin
      for (int c = 0; c < 7; c++) begin
        smp[c] = off[c] + ($random % 20);
        sum[c] += smp[c];
      end
      strobe(pack7(smp[0], smp[1], smp[2], smp[3], smp[4], smp[5], smp[6]));
    end
    step();
    exp_v = pack7(sum[0] / 1024, sum[1] / 1024, sum[2] / 1024, sum[3] / 1024,
                  sum[4] / 1024, sum[5] / 1024, sum[6] / 1024);
    chk("t2_random_bias", bias, exp_v);

    // Truncation toward zero at small negative/positive sums
    key_pulse();
    strobe(pack7(-1, -1023, -1024, -1025, 1025, 0, 0));
    repeat (1023) strobe('0);
    step();
    chk("t2_trunc_bias", bias, bneg);

    // config_done drop mid-run returns to IDLE, bias held
    key_pulse();
    repeat (500) strobe(v100);
    cfg = 1'b0;
    step();
    chk("t4_busy_idle", {111'd0, busy}, 112'd0);
    chk("t4_done_low", {111'd0, done}, 112'd0);
    chk("t4_bias_held", bias, bneg);
    key_pulse();
    chk("t4_key_idle_ignored", {111'd0, busy}, 112'd0);
    cfg = 1'b1;
    step();
    repeat (1023) strobe(v100);
    step(); step();
    chk("t4_1023_no_done", {111'd0, done}, 112'd0);
    strobe(v100);
    step();
    chk("t4_done", {111'd0, done}, 112'd1);
    chk("t4_bias", bias, v100);

    // Warm-up discard with a small instance
    s_cfg = 1'b1;
    step();
    chk("t5_busy", {111'd0, s_busy}, 112'd1);
    repeat (4) strobe_s(pack7(1000, 1000, 1000, 1000, 1000, 1000, 1000));
    repeat (8) strobe_s(pack7(10, 10, 10, 10, 10, 10, 10));
    step();
    chk("t5_bias", s_bias, pack7(10, 10, 10, 10, 10, 10, 10));
    chk("t5_done", {111'd0, s_done}, 112'd1);
    s_key = 1'b1;
    step();
    s_key = 1'b0;
    repeat (4) strobe_s(pack7(1000, 1000, 1000, 1000, 1000, 1000, 1000));
    repeat (3) strobe_s(pack7(10, 10, 10, 10, 10, 10, 10));
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("t5_rst_bias", s_bias, '0);
    chk("t5_rst_done", {111'd0, s_done}, 112'd0);
    chk("t5_rst_busy", {111'd0, s_busy}, 112'd0);
    s_rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
